// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - instruction queue push/pop and status bundle
interface instr_queue_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int OP_W   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] DATA;
  logic              Load;
  logic              Next;
  logic              Flush;
  logic [DATA_W-1:0] IR;
  logic [OP_W-1:0]   Opcode;
  logic              IR_valid;
  logic              Full;
  logic [CNT_W-1:0]  Count;
  logic              Overflow;

  modport master (
    output DATA, Load, Next, Flush,
    input  IR, Opcode, IR_valid, Full, Count, Overflow
  );

  modport slave (
    input  DATA, Load, Next, Flush,
    output IR, Opcode, IR_valid, Full, Count, Overflow
  );
endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - DEPTH-entry instruction FIFO between fetch and control FSM
module instr_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int OP_W   = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  instr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic              valid;
  logic              full;
  logic              pop_ok;
  logic              push_ok;
  logic [DATA_W-1:0] ir;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  // Flush and Reset swallow any push/pop in the same cycle.
  assign pop_ok  = q.Next && valid && !Reset && !q.Flush;
  assign push_ok = q.Load && (!full || pop_ok) && !Reset && !q.Flush;

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= q.DATA;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || q.Flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_W'(1);
      end
      if (q.Load && full && !pop_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ir         = valid ? mem[rd_ptr] : '0;
  assign q.IR       = ir;
  assign q.Opcode   = ir[DATA_W-1 -: OP_W];
  assign q.IR_valid = valid;
  assign q.Full     = full;
  assign q.Count    = count;
  assign q.Overflow = overflow;
endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - queue-model bench for instr_queue with directed vectors
module tb_instr_queue;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int OP_W   = 4;

  logic Clock;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  instr_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) q ();

  instr_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .q     (q.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the queue as a plain list of words plus a sticky overflow bit.
  logic [DATA_W-1:0] mq[$];
  bit                m_ovf = 0;

  always @(posedge Clock) begin
    bit pop, push, was_full;
    if (Reset || q.Flush) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      pop      = q.Next && (mq.size() > 0);
      push     = q.Load && (!was_full || pop);
      if (q.Load && was_full && !pop) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(q.DATA);
    end
  end

  always @(negedge Clock) begin
    logic [DATA_W-1:0] exp_ir;
    if (chk_en) begin
      exp_ir = (mq.size() > 0) ? mq[0] : '0;
      chk("ir",       32'(q.IR),       32'(exp_ir));
      chk("opcode",   32'(q.Opcode),   32'(exp_ir[DATA_W-1 -: OP_W]));
      chk("ir_valid", 32'(q.IR_valid), 32'(mq.size() > 0));
      chk("full",     32'(q.Full),     32'(mq.size() == DEPTH));
      chk("count",    32'(q.Count),    32'(mq.size()));
      chk("overflow", 32'(q.Overflow), 32'(m_ovf));
    end
  end

  task automatic cyc(input logic rst, input logic ld, input logic nx,
                     input logic fl, input logic [DATA_W-1:0] d);
    Reset   = rst;
    q.Load  = ld;
    q.Next  = nx;
    q.Flush = fl;
    q.DATA  = d;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] w;

    // 1: reset dominates a concurrent load
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 16'hFA43);
      chk_en = 1;
      chk("rst_ir",    32'(q.IR), 32'h0);
      chk("rst_count", 32'(q.Count), 32'h0);
      chk("rst_valid", 32'(q.IR_valid), 32'h0);
      chk("rst_ovf",   32'(q.Overflow), 32'h0);
    end

    // 2: fill, overflow, drain
    cyc(0, 1, 0, 0, 16'h1111);
    chk("first_ir", 32'(q.IR), 32'h1111);
    cyc(0, 1, 0, 0, 16'h2222);
    cyc(0, 1, 0, 0, 16'h3333);
    cyc(0, 1, 0, 0, 16'h4444);
    chk("fill_full",   32'(q.Full), 32'h1);
    chk("fill_count",  32'(q.Count), 32'h4);
    chk("fill_ir",     32'(q.IR), 32'h1111);
    chk("fill_opcode", 32'(q.Opcode), 32'h1);
    cyc(0, 1, 0, 0, 16'h5555);
    chk("ovf_set",   32'(q.Overflow), 32'h1);
    chk("ovf_count", 32'(q.Count), 32'h4);
    cyc(0, 0, 1, 0, '0);
    chk("pop1_ir", 32'(q.IR), 32'h2222);
    cyc(0, 0, 1, 0, '0);
    chk("pop2_ir", 32'(q.IR), 32'h3333);
    cyc(0, 0, 1, 0, '0);
    chk("pop3_ir", 32'(q.IR), 32'h4444);
    cyc(0, 0, 1, 0, '0);
    chk("pop4_ir",    32'(q.IR), 32'h0);
    chk("pop4_valid", 32'(q.IR_valid), 32'h0);

    // 3: sustained push+pop at Count=2 across pointer wrap
    cyc(0, 1, 0, 0, 16'hA000);
    cyc(0, 1, 0, 0, 16'hA001);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1, 0, 16'hF000 + 16'(i));
      w = (i == 0) ? 16'hA001 : 16'hF000 + 16'(i - 1);
      chk("stream_count", 32'(q.Count), 32'h2);
      chk("stream_ir",    32'(q.IR), 32'(w));
    end
    chk("ovf_sticky", 32'(q.Overflow), 32'h1);

    // 4: flush at Count=3 ignores load
    cyc(0, 1, 0, 0, 16'hF00A);
    chk("pre_flush_count", 32'(q.Count), 32'h3);
    cyc(0, 1, 1, 1, 16'hF0F0);
    chk("flush_count", 32'(q.Count), 32'h0);
    chk("flush_ir",    32'(q.IR), 32'h0);
    chk("flush_ovf",   32'(q.Overflow), 32'h0);

    // 5: pop on empty ignored; load+next on empty keeps the push
    cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 1, 0, '0);
    chk("empty_pop_count", 32'(q.Count), 32'h0);
    cyc(0, 1, 1, 0, 16'hABCD);
    chk("empty_ldnx_count", 32'(q.Count), 32'h1);
    chk("empty_ldnx_ir",    32'(q.IR), 32'hABCD);

    // 6: reset mid-stream, then recover
    cyc(0, 1, 0, 0, 16'h1234);
    chk("pre_rst_count", 32'(q.Count), 32'h2);
    cyc(1, 1, 0, 0, 16'h5A5A);
    chk("mid_rst_count", 32'(q.Count), 32'h0);
    chk("mid_rst_ir",    32'(q.IR), 32'h0);
    cyc(0, 1, 0, 0, 16'h0F0F);
    chk("post_rst_ir", 32'(q.IR), 32'h0F0F);

    // Count=1 swap, then full with simultaneous push+pop
    cyc(0, 1, 1, 0, 16'h7777);
    chk("swap_ir",    32'(q.IR), 32'h7777);
    chk("swap_count", 32'(q.Count), 32'h1);
    cyc(0, 1, 0, 0, 16'h8888);
    cyc(0, 1, 0, 0, 16'h9999);
    cyc(0, 1, 0, 0, 16'hBBBB);
    cyc(0, 1, 1, 0, 16'hCCCC);
    chk("full_ldnx_count", 32'(q.Count), 32'h4);
    chk("full_ldnx_ir",    32'(q.IR), 32'h8888);
    chk("full_ldnx_ovf",   32'(q.Overflow), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, '0);
    chk("drain_valid", 32'(q.IR_valid), 32'h0);

    cyc(0, 0, 0, 0, '0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
